// File: rtl/note_sequencer.sv
// Pattern sequencer: fetches {note,len} words from a 1-cycle ROM and plays them on a tick/unit timebase.
// Start-to-note latency 3 cycles, 2 cycles between notes, no backpressure; NOTE_SEQ_VIBRATO_EN adds a vibrato phase counter.
module note_sequencer #(
    parameter int CLOCKS_PER_TICK = 415_667,
    parameter int TICKS_PER_UNIT  = 5,
    parameter int ADDR_WIDTH      = 4,
    parameter int NOTE_WIDTH      = 6,
    parameter int LEN_WIDTH       = 5,
    parameter int ENV_WIDTH       = 9,
    parameter int ENV_STEP        = 2,
    parameter int ENV_MAX         = 30
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic                            i_stop,
    input  logic                            i_loop,
    input  logic [ADDR_WIDTH-1:0]           i_end_addr,
    output logic [ADDR_WIDTH-1:0]           o_pat_addr,
    input  logic [NOTE_WIDTH+LEN_WIDTH-1:0] i_pat_data,
    output logic [NOTE_WIDTH-1:0]           o_note,
    output logic                            o_new_note,
    output logic [ENV_WIDTH-1:0]            o_envelope,
    output logic [2:0]                      o_vibrato_index,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_tick
);

    localparam int TW = (CLOCKS_PER_TICK > 1) ? $clog2(CLOCKS_PER_TICK) : 1;
    localparam int UW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_DONE} state_t;

    state_t                  state_q;
    logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
    logic                    tick_q, tick_wrap;
    logic [UW-1:0]           unit_cnt_q;
    logic                    unit_wrap, unit_pulse;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [NOTE_WIDTH-1:0]   note_q;
    logic [LEN_WIDTH-1:0]    len_q, dur_q;
    logic [ENV_WIDTH-1:0]    env_q, env_d;
    logic [ENV_WIDTH:0]      env_sum;
    logic                    new_note_q, busy_q, done_q;

    always_comb begin
        tick_wrap  = (tick_cnt_q == TW'(CLOCKS_PER_TICK - 1));
        tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TW'(1);
        unit_wrap  = (unit_cnt_q == UW'(TICKS_PER_UNIT - 1));
        unit_pulse = (state_q == S_PLAY) && tick_q && unit_wrap;
        // one extra bit so the saturation compare cannot be fooled by overflow
        env_sum    = {1'b0, env_q} + (ENV_WIDTH+1)'(ENV_STEP);
        env_d      = (env_sum > (ENV_WIDTH+1)'(ENV_MAX)) ? ENV_WIDTH'(ENV_MAX) : env_sum[ENV_WIDTH-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_wrap;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            unit_cnt_q <= '0;
            addr_q     <= '0;
            note_q     <= '0;
            len_q      <= '0;
            dur_q      <= '0;
            env_q      <= '0;
            new_note_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            new_note_q <= 1'b0;
            done_q     <= 1'b0;
            if (i_stop) begin
                state_q <= S_IDLE;
                note_q  <= '0;
                env_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (i_start) begin
                            addr_q  <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                    S_FETCH: state_q <= S_LOAD;
                    S_LOAD: begin
                        note_q     <= i_pat_data[NOTE_WIDTH+LEN_WIDTH-1:LEN_WIDTH];
                        len_q      <= i_pat_data[LEN_WIDTH-1:0];
                        dur_q      <= '0;
                        unit_cnt_q <= '0;
                        env_q      <= '0;
                        new_note_q <= 1'b1;
                        state_q    <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (tick_q) begin
                            env_q      <= env_d;
                            unit_cnt_q <= unit_wrap ? '0 : unit_cnt_q + UW'(1);
                        end
                        if (unit_pulse) begin
                            if (dur_q != len_q) begin
                                dur_q <= dur_q + LEN_WIDTH'(1);
                            end else if (addr_q != i_end_addr) begin
                                addr_q  <= addr_q + ADDR_WIDTH'(1);
                                state_q <= S_FETCH;
                            end else if (i_loop) begin
                                addr_q  <= '0;
                                state_q <= S_FETCH;
                            end else begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        note_q  <= '0;
                        env_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

`ifdef NOTE_SEQ_VIBRATO_EN
    logic [2:0] vib_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_stop || state_q == S_LOAD) begin
            vib_q <= '0;
        end else if (state_q == S_PLAY && tick_q) begin
            vib_q <= vib_q + 3'd1;
        end
    end

    assign o_vibrato_index = vib_q;
`else
    assign o_vibrato_index = 3'd0;
`endif

    assign o_pat_addr = addr_q;
    assign o_note     = note_q;
    assign o_new_note = new_note_q;
    assign o_envelope = env_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_tick     = tick_q;

endmodule
